// File: rtl/spi_flash_pkg.sv
// rtl/spi_flash_pkg.sv - opcodes and FSM state encoding for the SPI flash target
package spi_flash_pkg;

    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_PP   = 8'h02;
    localparam logic [7:0] OP_RDID = 8'h9F;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_WRDI = 8'h04;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_CMD    = 4'd1;
    localparam logic [3:0] S_ADDR0  = 4'd2;
    localparam logic [3:0] S_ADDR1  = 4'd3;
    localparam logic [3:0] S_ADDR2  = 4'd4;
    localparam logic [3:0] S_RDATA  = 4'd5;
    localparam logic [3:0] S_PDATA  = 4'd6;
    localparam logic [3:0] S_ID     = 4'd7;
    localparam logic [3:0] S_STAT   = 4'd8;
    localparam logic [3:0] S_IGNORE = 4'd9;

endpackage

// File: rtl/spi_flash_target_if.sv
// rtl/spi_flash_target_if.sv - SPI pins, host preload port and status of the flash target
interface spi_flash_target_if #(
    parameter int AW = 8
);
    logic          i_cs;
    logic          i_sclk;
    logic          i_copi;
    logic          o_cipo;
    logic          o_cipo_oe;
    logic          i_wr;
    logic [AW-1:0] i_waddr;
    logic [7:0]    i_wdata;
    logic          o_busy;
    logic [7:0]    o_opcode;

    modport master (
        output i_cs, i_sclk, i_copi, i_wr, i_waddr, i_wdata,
        input  o_cipo, o_cipo_oe, o_busy, o_opcode
    );

    modport slave (
        input  i_cs, i_sclk, i_copi, i_wr, i_waddr, i_wdata,
        output o_cipo, o_cipo_oe, o_busy, o_opcode
    );
endinterface

// File: rtl/spi_target_shift.sv
// rtl/spi_target_shift.sv - pin synchronizers, SCLK/CS edge detect and byte shift registers
module spi_target_shift (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cs,
    input  logic       i_sclk,
    input  logic       i_copi,
    input  logic [7:0] i_tx_byte,
    output logic       o_cs_fall,
    output logic       o_cs_rise,
    output logic       o_byte_done,
    output logic [7:0] o_rx_byte,
    output logic       o_tx_msb
);
    logic [2:0] r_cs_s;
    logic [2:0] r_sclk_s;
    logic [1:0] r_copi_s;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_rx;
    logic [7:0] r_tx;
    logic       r_load_pend;
    logic       r_byte_done;
    logic [7:0] r_rx_byte;
    logic       w_sclk_rise;
    logic       w_sclk_fall;

    assign w_sclk_rise = r_sclk_s[1] & ~r_sclk_s[2];
    assign w_sclk_fall = ~r_sclk_s[1] & r_sclk_s[2];
    assign o_cs_fall   = ~r_cs_s[1] & r_cs_s[2];
    assign o_cs_rise   = r_cs_s[1] & ~r_cs_s[2];
    assign o_byte_done = r_byte_done;
    assign o_rx_byte   = r_rx_byte;
    assign o_tx_msb    = r_tx[7];

    // CS sync resets to "low" so a reset inside a CS-low period never fakes a falling edge
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cs_s      <= 3'b000;
            r_sclk_s    <= 3'b000;
            r_copi_s    <= 2'b00;
            r_bit_cnt   <= 3'd0;
            r_rx        <= 8'h00;
            r_tx        <= 8'h00;
            r_load_pend <= 1'b0;
            r_byte_done <= 1'b0;
            r_rx_byte   <= 8'h00;
        end else begin
            r_cs_s      <= {r_cs_s[1:0], i_cs};
            r_sclk_s    <= {r_sclk_s[1:0], i_sclk};
            r_copi_s    <= {r_copi_s[0], i_copi};
            r_byte_done <= 1'b0;
            if (r_cs_s[1] || o_cs_fall) begin
                r_bit_cnt   <= 3'd0;
                r_rx        <= 8'h00;
                r_tx        <= 8'h00;
                r_load_pend <= 1'b0;
            end else begin
                if (w_sclk_rise) begin
                    r_rx      <= {r_rx[6:0], r_copi_s[1]};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        r_byte_done <= 1'b1;
                        r_rx_byte   <= {r_rx[6:0], r_copi_s[1]};
                        r_load_pend <= 1'b1;
                    end
                end
                if (w_sclk_fall) begin
                    if (r_load_pend) begin
                        r_tx        <= i_tx_byte;
                        r_load_pend <= 1'b0;
                    end else begin
                        r_tx <= {r_tx[6:0], 1'b0};
                    end
                end
            end
        end
    end
endmodule

// File: rtl/spi_flash_target.sv
// rtl/spi_flash_target.sv - SPI mode-0 serial NOR flash emulator with host-preloadable memory
module spi_flash_target #(
    parameter int unsigned CLK_FREQ = 48_000_000,
    parameter int unsigned DEPTH    = 256,
    parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
    input logic               i_clk,
    input logic               i_rst,
    spi_flash_target_if.slave bus
);
    import spi_flash_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PAGE_MASK = AW'(8'hFF);

    logic [3:0]    r_state;
    logic [AW-1:0] r_addr;
    logic [1:0]    r_id_idx;
    logic          r_wel;
    logic          r_pp_data;
    logic          r_busy;
    logic          r_oe;
    logic [7:0]    r_opcode;
    logic [7:0]    r_rd_data;
    logic [7:0]    r_mem [DEPTH];

    logic          w_cs_fall;
    logic          w_cs_rise;
    logic          w_byte_done;
    logic [7:0]    w_rx_byte;
    logic          w_tx_msb;
    logic [7:0]    w_tx_byte;
    logic          w_spi_we;
    logic [AW-1:0] w_page_inc;

    spi_target_shift u_shift (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_cs       (bus.i_cs),
        .i_sclk     (bus.i_sclk),
        .i_copi     (bus.i_copi),
        .i_tx_byte  (w_tx_byte),
        .o_cs_fall  (w_cs_fall),
        .o_cs_rise  (w_cs_rise),
        .o_byte_done(w_byte_done),
        .o_rx_byte  (w_rx_byte),
        .o_tx_msb   (w_tx_msb)
    );

    assign bus.o_cipo    = r_oe & w_tx_msb;
    assign bus.o_cipo_oe = r_oe;
    assign bus.o_busy    = r_busy;
    assign bus.o_opcode  = r_opcode;

    assign w_spi_we   = w_byte_done && (r_state == S_PDATA) && !w_cs_rise && !w_cs_fall;
    assign w_page_inc = (r_addr & ~PAGE_MASK) | ((r_addr + AW'(1)) & PAGE_MASK);

    always_comb begin
        w_tx_byte = 8'h00;
        case (r_state)
            S_RDATA: w_tx_byte = r_rd_data;
            S_STAT:  w_tx_byte = {6'b0, r_wel, 1'b0};
            S_ID: begin
                case (r_id_idx)
                    2'd0:    w_tx_byte = JEDEC_ID[23:16];
                    2'd1:    w_tx_byte = JEDEC_ID[15:8];
                    2'd2:    w_tx_byte = JEDEC_ID[7:0];
                    default: w_tx_byte = 8'h00;
                endcase
            end
            default: w_tx_byte = 8'h00;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_id_idx  <= 2'd0;
            r_wel     <= 1'b0;
            r_pp_data <= 1'b0;
            r_busy    <= 1'b0;
            r_oe      <= 1'b0;
            r_opcode  <= 8'h00;
        end else if (w_cs_rise) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_oe      <= 1'b0;
            r_pp_data <= 1'b0;
            if (r_pp_data) r_wel <= 1'b0;
        end else if (w_cs_fall) begin
            r_state   <= S_CMD;
            r_busy    <= 1'b1;
            r_oe      <= 1'b0;
            r_pp_data <= 1'b0;
        end else if (w_byte_done) begin
            case (r_state)
                S_CMD: begin
                    r_opcode <= w_rx_byte;
                    r_state  <= S_IGNORE;
                    case (w_rx_byte)
                        OP_READ: r_state <= S_ADDR0;
                        OP_PP:   if (r_wel) r_state <= S_ADDR0;
                        OP_RDID: begin
                            r_state  <= S_ID;
                            r_id_idx <= 2'd0;
                            r_oe     <= 1'b1;
                        end
                        OP_RDSR: begin
                            r_state <= S_STAT;
                            r_oe    <= 1'b1;
                        end
                        OP_WREN: r_wel <= 1'b1;
                        OP_WRDI: r_wel <= 1'b0;
                        default: r_state <= S_IGNORE;
                    endcase
                end
                S_ADDR0: begin
                    r_addr  <= AW'({r_addr, w_rx_byte});
                    r_state <= S_ADDR1;
                end
                S_ADDR1: begin
                    r_addr  <= AW'({r_addr, w_rx_byte});
                    r_state <= S_ADDR2;
                end
                S_ADDR2: begin
                    r_addr <= AW'({r_addr, w_rx_byte});
                    if (r_opcode == OP_PP) begin
                        r_state <= S_PDATA;
                    end else begin
                        r_state <= S_RDATA;
                        r_oe    <= 1'b1;
                    end
                end
                S_RDATA: r_addr <= r_addr + AW'(1);
                S_PDATA: begin
                    r_addr    <= w_page_inc;
                    r_pp_data <= 1'b1;
                end
                S_ID: if (r_id_idx != 2'd3) r_id_idx <= r_id_idx + 2'd1;
                default: r_state <= r_state;
            endcase
        end
    end

    // SPI program data takes the port over a simultaneous host preload
    always_ff @(posedge i_clk) begin
        if (w_spi_we) begin
            r_mem[r_addr] <= w_rx_byte;
        end else if (bus.i_wr) begin
            r_mem[bus.i_waddr] <= bus.i_wdata;
        end
        r_rd_data <= r_mem[r_addr];
    end
endmodule

// File: tb/tb_spi_flash_target.sv
// tb/tb_spi_flash_target.sv - randomized self-checking bench for spi_flash_target
module tb_spi_flash_target;
    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int HALF  = 5;
    localparam logic [23:0] JID = 24'hEF4016;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_flash_target_if #(.AW(AW)) bus ();

    spi_flash_target #(.CLK_FREQ(100_000_000), .DEPTH(DEPTH), .JEDEC_ID(JID)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] model_mem [DEPTH];
    bit         model_wel = 1'b0;
    logic [7:0] rx_q [$];
    logic [7:0] pp_q [$];

    function automatic int rd_idx(input logic [23:0] a, input int i);
        return (int'(a) % DEPTH + i) % DEPTH;
    endfunction

    function automatic int pp_idx(input logic [23:0] a, input int i);
        int base;
        base = int'(a) % DEPTH;
        return (base / 256) * 256 + (base % 256 + i) % 256;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            bus.i_copi = tx[7-i];
            wait_clk(HALF);
            bus.i_sclk = 1'b1;
            rx = {rx[6:0], bus.o_cipo};
            wait_clk(HALF);
            bus.i_sclk = 1'b0;
        end
    endtask

    task automatic cs_begin();
        @(negedge clk);
        bus.i_cs = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic cs_end();
        wait_clk(HALF);
        bus.i_cs = 1'b1;
        wait_clk(8);
    endtask

    task automatic host_write(input int a, input logic [7:0] d);
        @(negedge clk);
        bus.i_wr    = 1'b1;
        bus.i_waddr = AW'(a);
        bus.i_wdata = d;
        @(negedge clk);
        bus.i_wr = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic spi_cmd_addr(input logic [7:0] op, input logic [23:0] a);
        logic [7:0] r;
        spi_bits(op, 8, r);
        spi_bits(a[23:16], 8, r);
        spi_bits(a[15:8], 8, r);
        spi_bits(a[7:0], 8, r);
    endtask

    task automatic spi_read(input logic [23:0] a, input int n);
        logic [7:0] r;
        rx_q.delete();
        cs_begin();
        spi_cmd_addr(8'h03, a);
        for (int i = 0; i < n; i++) begin
            spi_bits(8'h00, 8, r);
            rx_q.push_back(r);
        end
        cs_end();
    endtask

    task automatic spi_pp(input logic [23:0] a);
        logic [7:0] r;
        cs_begin();
        spi_cmd_addr(8'h02, a);
        foreach (pp_q[i]) spi_bits(pp_q[i], 8, r);
        cs_end();
        if (model_wel) begin
            foreach (pp_q[i]) model_mem[pp_idx(a, i)] = pp_q[i];
            if (pp_q.size() > 0) model_wel = 1'b0;
        end
    endtask

    task automatic spi_simple(input logic [7:0] op);
        logic [7:0] r;
        cs_begin();
        spi_bits(op, 8, r);
        cs_end();
        if (op == 8'h06) model_wel = 1'b1;
        if (op == 8'h04) model_wel = 1'b0;
    endtask

    task automatic spi_status(output logic [7:0] st);
        logic [7:0] r;
        cs_begin();
        spi_bits(8'h05, 8, r);
        spi_bits(8'h00, 8, st);
        cs_end();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_cs = 1'b1; bus.i_sclk = 1'b0; bus.i_copi = 1'b0;
        bus.i_wr = 1'b0; bus.i_waddr = '0; bus.i_wdata = 8'h00;
        wait_clk(4);
        n_tests += 4;
        if (bus.o_cipo !== 1'b0) begin n_fail++; $display("FAIL reset_cipo: got %b expected 0", bus.o_cipo); end
        if (bus.o_cipo_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b expected 0", bus.o_cipo_oe); end
        if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.o_busy); end
        if (bus.o_opcode !== 8'h00) begin n_fail++; $display("FAIL reset_opcode: got %02h expected 00", bus.o_opcode); end
        rst = 1'b0;
        wait_clk(8);
        for (int i = 0; i < DEPTH; i++) host_write(i, 8'($urandom));
    endtask

    task automatic test_read_basic();
        host_write(16'h10, 8'hA5);
        host_write(16'h11, 8'h5A);
        spi_read(24'h000010, 2);
        n_tests += 3;
        if (rx_q[0] !== 8'hA5) begin n_fail++; $display("FAIL read_b0: got %02h expected a5", rx_q[0]); end
        if (rx_q[1] !== 8'h5A) begin n_fail++; $display("FAIL read_b1: got %02h expected 5a", rx_q[1]); end
        if (bus.o_opcode !== 8'h03) begin n_fail++; $display("FAIL read_opcode: got %02h expected 03", bus.o_opcode); end
    endtask

    task automatic test_jedec();
        logic [7:0] exp [4];
        logic [7:0] r;
        exp[0] = JID[23:16]; exp[1] = JID[15:8]; exp[2] = JID[7:0]; exp[3] = 8'h00;
        cs_begin();
        spi_bits(8'h9F, 8, r);
        for (int i = 0; i < 4; i++) begin
            spi_bits(8'h00, 8, r);
            n_tests++;
            if (r !== exp[i]) begin n_fail++; $display("FAIL jedec_b%0d: got %02h expected %02h", i, r, exp[i]); end
        end
        n_tests += 2;
        if (bus.o_cipo_oe !== 1'b1) begin n_fail++; $display("FAIL jedec_oe: got %b expected 1", bus.o_cipo_oe); end
        if (bus.o_opcode !== 8'h9F) begin n_fail++; $display("FAIL jedec_opcode: got %02h expected 9f", bus.o_opcode); end
        cs_end();
    endtask

    task automatic test_read_wrap();
        host_write(8'hFF, 8'h11);
        host_write(8'h00, 8'h22);
        spi_read(24'h0000FF, 2);
        n_tests += 2;
        if (rx_q[0] !== 8'h11) begin n_fail++; $display("FAIL wrap_b0: got %02h expected 11", rx_q[0]); end
        if (rx_q[1] !== 8'h22) begin n_fail++; $display("FAIL wrap_b1: got %02h expected 22", rx_q[1]); end
    endtask

    task automatic test_program();
        logic [7:0] old, st, r;
        old = 8'($urandom) ^ 8'hAB;
        host_write(8'h20, old);
        pp_q = '{8'hAB};
        spi_pp(24'h000020);
        spi_read(24'h000020, 1);
        n_tests++;
        if (rx_q[0] !== old) begin n_fail++; $display("FAIL pp_no_wel: got %02h expected %02h", rx_q[0], old); end
        cs_begin();
        spi_bits(8'h06, 8, r);
        spi_bits(8'h00, 8, r);
        n_tests++;
        if (bus.o_cipo_oe !== 1'b0) begin n_fail++; $display("FAIL ignore_oe: got %b expected 0", bus.o_cipo_oe); end
        cs_end();
        model_wel = 1'b1;
        spi_status(st);
        n_tests++;
        if (st !== 8'h02) begin n_fail++; $display("FAIL status_wel: got %02h expected 02", st); end
        pp_q = '{8'hC1, 8'hC2};
        spi_pp(24'h0000FF);
        spi_read(24'h0000FF, 2);
        n_tests += 2;
        if (rx_q[0] !== 8'hC1) begin n_fail++; $display("FAIL pp_b0: got %02h expected c1", rx_q[0]); end
        if (rx_q[1] !== 8'hC2) begin n_fail++; $display("FAIL pp_b1: got %02h expected c2", rx_q[1]); end
        spi_status(st);
        n_tests++;
        if (st !== 8'h00) begin n_fail++; $display("FAIL status_clr: got %02h expected 00", st); end
    endtask

    task automatic test_abort();
        logic [7:0] r;
        int cnt;
        cs_begin();
        spi_bits(8'h03, 8, r);
        spi_bits(8'($urandom), 8, r);
        spi_bits(8'($urandom), 4, r);
        wait_clk(HALF);
        bus.i_cs = 1'b1;
        cnt = 0;
        while (bus.o_busy !== 1'b0 && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        n_tests++;
        if (cnt > 3) begin n_fail++; $display("FAIL busy_fall: got %0d cycles expected <= 3", cnt); end
        wait_clk(8);
        cs_begin();
        spi_bits(8'h9F, 8, r);
        for (int i = 0; i < 3; i++) begin
            spi_bits(8'h00, 8, r);
            n_tests++;
            if (r !== JID[23-8*i -: 8]) begin
                n_fail++; $display("FAIL abort_id_b%0d: got %02h expected %02h", i, r, JID[23-8*i -: 8]);
            end
        end
        cs_end();
    endtask

    task automatic test_reset_mid();
        logic [23:0] a;
        logic [7:0]  r;
        a = 24'($urandom);
        cs_begin();
        spi_cmd_addr(8'h03, a);
        spi_bits(8'h00, 8, r);
        n_tests++;
        if (r !== model_mem[rd_idx(a, 0)]) begin n_fail++; $display("FAIL rstmid_b0: got %02h expected %02h", r, model_mem[rd_idx(a, 0)]); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_wel = 1'b0;
        n_tests += 2;
        if (bus.o_cipo_oe !== 1'b0) begin n_fail++; $display("FAIL rstmid_oe: got %b expected 0", bus.o_cipo_oe); end
        if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", bus.o_busy); end
        cs_end();
        a = 24'($urandom);
        spi_read(a, 4);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (rx_q[i] !== model_mem[rd_idx(a, i)]) begin
                n_fail++; $display("FAIL rstmid_read_b%0d: got %02h expected %02h", i, rx_q[i], model_mem[rd_idx(a, i)]);
            end
        end
    endtask

    task automatic test_random();
        logic [23:0] a;
        logic [7:0]  st;
        int n;
        for (int t = 0; t < 6; t++) begin
            a = 24'($urandom);
            n = $urandom_range(1, 6);
            spi_read(a, n);
            for (int i = 0; i < n; i++) begin
                n_tests++;
                if (rx_q[i] !== model_mem[rd_idx(a, i)]) begin
                    n_fail++; $display("FAIL rand_read_t%0d_b%0d: got %02h expected %02h", t, i, rx_q[i], model_mem[rd_idx(a, i)]);
                end
            end
        end
        for (int t = 0; t < 4; t++) begin
            if ($urandom_range(0, 1) == 1) spi_simple(8'h06);
            else spi_simple(8'h04);
            a = {16'($urandom), 8'($urandom_range(250, 255))};
            pp_q.delete();
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) pp_q.push_back(8'($urandom));
            spi_pp(a);
            spi_status(st);
            n_tests++;
            if (st !== {6'b0, model_wel, 1'b0}) begin n_fail++; $display("FAIL rand_status_t%0d: got %02h expected %02h", t, st, {6'b0, model_wel, 1'b0}); end
            a = {a[23:8], a[7:0] - 8'd2};
            spi_read(a, 8);
            for (int i = 0; i < 8; i++) begin
                n_tests++;
                if (rx_q[i] !== model_mem[rd_idx(a, i)]) begin
                    n_fail++; $display("FAIL rand_pp_t%0d_b%0d: got %02h expected %02h", t, i, rx_q[i], model_mem[rd_idx(a, i)]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_jedec();
        test_read_wrap();
        test_program();
        test_abort();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
